// File: rtl/farm_sensor_conditioner.sv
// Farm-road sensor front end: synchronise, debounce, qualify presence, then latch a
// request that is held until the controller reports farm green.
module farm_sensor_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int PRESENCE_CYCLES = 100000000,
    parameter int CNT_WIDTH       = 31
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       sensorRaw,
    input  logic       farmGreen,
    output logic       farmRequest,
    output logic       sensorClean,
    output logic [1:0] state
);

    typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, REQUEST = 2'd2, SERVED = 2'd3} state_t;

    localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] PRES_LAST = CNT_WIDTH'(PRESENCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   sensorSync;
    logic [CNT_WIDTH-1:0]   dbCnt;
    logic [CNT_WIDTH-1:0]   presCnt, presCntNext;
    state_t                 stateReg, stateNext;

    assign sensorSync = syncChain[SYNC_STAGES-1];
    assign state      = stateReg;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            syncChain <= '0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], sensorRaw};
        end
    end

    // Counter restarts whenever the synced level agrees with the clean one, so any
    // disagreement shorter than DEBOUNCE_CYCLES never reaches sensorClean.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sensorClean <= 1'b0;
            dbCnt       <= '0;
        end else if (sensorSync == sensorClean) begin
            dbCnt <= '0;
        end else if (dbCnt == DB_LAST) begin
            sensorClean <= sensorSync;
            dbCnt       <= '0;
        end else begin
            dbCnt <= dbCnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stateReg    <= IDLE;
            presCnt     <= '0;
            farmRequest <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            presCnt     <= presCntNext;
            farmRequest <= (stateNext == REQUEST);
        end
    end

    always_comb begin
        stateNext   = stateReg;
        presCntNext = '0;
        case (stateReg)
            IDLE: begin
                if (sensorClean) stateNext = PRESENT;
            end
            PRESENT: begin
                // A falling sensor beats qualification on the same cycle.
                if (!sensorClean) begin
                    stateNext = IDLE;
                end else if (presCnt == PRES_LAST) begin
                    stateNext = REQUEST;
                end else begin
                    presCntNext = presCnt + 1'b1;
                end
            end
            REQUEST: begin
                if (farmGreen) stateNext = SERVED;
            end
            SERVED: begin
                if (!sensorClean && !farmGreen) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Directed bench: per-cycle vector table for the conditioning/latching flow, plus an
// asynchronous reset taken mid-request.
module tb_farm_sensor_conditioner;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       sensorRaw = 1'b0;
    logic       farmGreen = 1'b0;
    logic       farmRequest;
    logic       sensorClean;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    farm_sensor_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PRESENCE_CYCLES(3), .CNT_WIDTH(31)
    ) dut (
        .Clk(Clk), .Rst(Rst), .sensorRaw(sensorRaw), .farmGreen(farmGreen),
        .farmRequest(farmRequest), .sensorClean(sensorClean), .state(state)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       raw;
        logic       green;
        logic       expClean;
        logic [1:0] expState;
        logic       expReq;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic raw, input logic green, input logic c,
                                input logic [1:0] s, input logic r, input int n);
        vec_t v;
        v.raw = raw; v.green = green; v.expClean = c; v.expState = s; v.expReq = r;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic c, input logic [1:0] s, input logic r);
        checks++;
        if (sensorClean !== c || state !== s || farmRequest !== r) begin
            errors++;
            $display("FAIL %s: got clean=%b state=%0d req=%b, want clean=%b state=%0d req=%b",
                     name, sensorClean, state, farmRequest, c, s, r);
        end
    endtask

    initial begin
        // 3-cycle pulse: debounce reaches 3 of 4, never flips
        add(1, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0, 4);
        // held high with 1010 bounce during PRESENT, request on cycle 10
        add(1, 0, 0, 0, 0, 5);
        add(1, 0, 1, 0, 0, 1);
        add(0, 0, 1, 1, 0, 1);
        add(1, 0, 1, 1, 0, 1);
        add(0, 0, 1, 1, 0, 1);
        add(1, 0, 1, 2, 1, 1);
        // drop sensor: request stays latched, then green serves it
        add(0, 0, 1, 2, 1, 5);
        add(0, 0, 0, 2, 1, 1);
        add(0, 1, 0, 3, 0, 1);
        // new vehicle while SERVED is not re-requested
        add(1, 1, 0, 3, 0, 5);
        add(1, 1, 1, 3, 0, 1);
        add(1, 0, 1, 3, 0, 3);
        add(0, 0, 1, 3, 0, 5);
        add(0, 0, 0, 3, 0, 1);
        add(0, 0, 0, 0, 0, 1);
        // 4-cycle pulse with green already high: latches, exits REQUEST next cycle
        add(1, 1, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 3);
        add(0, 1, 0, 2, 1, 1);
        add(0, 1, 0, 3, 0, 2);
        add(0, 0, 0, 0, 0, 1);

        #12;
        check("reset_state", 1'b0, 2'd0, 1'b0);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            sensorRaw = vecs[i].raw;
            farmGreen = vecs[i].green;
            @(posedge Clk); #1;
            check($sformatf("vec%0d", i), vecs[i].expClean, vecs[i].expState, vecs[i].expReq);
        end

        // Drive into REQUEST, then pull reset between clock edges
        sensorRaw = 1'b1;
        farmGreen = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        check("pre_reset_request", 1'b1, 2'd2, 1'b1);
        #3;
        Rst = 1'b0;
        #1;
        check("async_reset", 1'b0, 2'd0, 1'b0);
        sensorRaw = 1'b0;
        #7;
        Rst = 1'b1;
        repeat (3) begin
            @(posedge Clk); #1;
            check("after_reset", 1'b0, 2'd0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
